// File: rtl/multiplication.sv
// -----------------------------------------------------------------------------
// multiplication
//
// Sequential unsigned shift-and-add multiplier. It examines one multiplier bit
// per clock, so every product takes WIDTH RUN cycles, whatever the operand
// values are.
//
// state | meaning
// ------+----------------------------------------------------------------------
// IDLE  | waiting for start; Res holds the last product; done pulses for one
//       | cycle after a completion
// RUN   | one shift-and-add iteration per edge; start and A/B are ignored
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a multiplication (accepted in IDLE only)
//   A      in   WIDTH-bit unsigned multiplicand, captured at start acceptance
//   B      in   WIDTH-bit unsigned multiplier, captured at start acceptance
//   busy   out  high while a multiplication is in progress
//   done   out  one-cycle pulse, Res was updated on the previous edge
//   Res    out  2*WIDTH-bit registered product of the last completed operation
// -----------------------------------------------------------------------------
module multiplication #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   Res
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   // {carry, upper half, lower half}. The lower half starts out holding the
   // multiplier and is consumed one bit per shift while the product grows in
   // from the top, so one register serves as both.
   logic [2*WIDTH:0]     prod_q, prod_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   res_q, res_d;
   logic                 done_q, done_d;

   logic [WIDTH:0]       sum;
   logic [2*WIDTH:0]     shifted;

   always_comb begin
      // The upper half plus the multiplicand fits in WIDTH+1 bits. After each
      // shift the carry bit lands back in the upper half, so prod_q[2*WIDTH]
      // is always zero when the addition takes place.
      sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      shifted = {1'b0, sum, prod_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = A;
               prod_d  = {{(WIDTH+1){1'b0}}, B};
               cnt_d   = CW'(WIDTH);
               state_d = RUN;
            end
         end
         RUN: begin
            prod_d = shifted;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               res_d   = shifted[2*WIDTH-1:0];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign Res  = res_q;

endmodule

// File: tb/tb_multiplication.sv
module tb_multiplication;

   logic        clk;
   logic        rst_n;

   logic        start8;
   logic [7:0]  a8, b8;
   logic        busy8, done8;
   logic [15:0] res8;

   logic        start4;
   logic [3:0]  a4, b4;
   logic        busy4, done4;
   logic [7:0]  res4;

   int total = 0;
   int bad   = 0;

   logic [15:0] res_prev8 = '0;
   logic [7:0]  res_prev4 = '0;

   multiplication #(.WIDTH(8)) u8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .A     (a8),
      .B     (b8),
      .busy  (busy8),
      .done  (done8),
      .Res   (res8)
   );

   multiplication u4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .A     (a4),
      .B     (b4),
      .busy  (busy4),
      .done  (done4),
      .Res   (res4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation on the WIDTH=8 instance and returns in the done
   // cycle, so a caller may chain another operation back-to-back.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string tag);
      a8 = a; b8 = b; start8 = 1'b1;
      step();
      start8 = 1'b0;
      a8 = ~a; b8 = ~b;
      chk({tag, ".busy_acc"}, 32'(busy8), 32'd1);
      chk({tag, ".done_acc"}, 32'(done8), 32'd0);
      chk({tag, ".res_hold"}, 32'(res8), 32'(res_prev8));
      for (int i = 1; i < 8; i++) begin
         step();
         chk({tag, ".run"}, {30'd0, busy8, done8}, 32'd2);
      end
      step();
      chk({tag, ".done"}, 32'(done8), 32'd1);
      chk({tag, ".busy_end"}, 32'(busy8), 32'd0);
      chk({tag, ".res"}, 32'(res8), 32'(exp));
      res_prev8 = exp;
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp, input string tag);
      a4 = a; b4 = b; start4 = 1'b1;
      step();
      start4 = 1'b0;
      a4 = ~a; b4 = ~b;
      chk({tag, ".res_hold"}, 32'(res4), 32'(res_prev4));
      for (int i = 1; i < 4; i++) begin
         step();
         chk({tag, ".run"}, {30'd0, busy4, done4}, 32'd2);
      end
      step();
      chk({tag, ".end"}, {30'd0, busy4, done4}, 32'd1);
      chk({tag, ".res"}, 32'(res4), 32'(exp));
      res_prev4 = exp;
   endtask

   initial begin
      int ndone, done_at, nbusy;
      logic [3:0] ra, rb;

      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      #2;
      chk("rst.busy8", 32'(busy8), 32'd0);
      chk("rst.done8", 32'(done8), 32'd0);
      chk("rst.res8",  32'(res8),  32'd0);
      chk("rst.out4",  {busy4, done4, res4}, 32'd0);
      #10 rst_n = 1'b1;
      step();
      chk("idle.busy8", 32'(busy8), 32'd0);

      op8(8'd100, 8'd10, 16'd1000, "basic");
      step();
      chk("basic.done_drop", 32'(done8), 32'd0);
      chk("basic.res_keep", 32'(res8), 32'd1000);

      op8(8'd255, 8'd255, 16'hFE01, "max");
      step();
      op8(8'd0, 8'd200, 16'd0, "zero");
      step();

      // start is reasserted with new operands during RUN and must be ignored
      a8 = 8'd16; b8 = 8'd3; start8 = 1'b1;
      step();
      start8 = 1'b0;
      ndone = 0; done_at = 0; nbusy = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 4) begin a8 = 8'd90; b8 = 8'd9; start8 = 1'b1; end
         if (i == 6) start8 = 1'b0;
         step();
         if (done8) begin ndone++; done_at = i; end
         if (busy8) nbusy++;
      end
      chk("ign.ndone", 32'(ndone), 32'd1);
      chk("ign.done_at", 32'(done_at), 32'd8);
      chk("ign.nbusy", 32'(nbusy), 32'd7);
      chk("ign.res", 32'(res8), 32'd48);
      res_prev8 = 16'd48;

      op8(8'd200, 8'd40, 16'd8000, "b2b1");
      op8(8'd70, 8'd10, 16'd700, "b2b2");
      step();
      chk("b2b.done_drop", 32'(done8), 32'd0);

      // asynchronous reset between edges during RUN
      a8 = 8'd255; b8 = 8'd5; start8 = 1'b1;
      step();
      start8 = 1'b0;
      step();
      step();
      chk("abort.busy_pre", 32'(busy8), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort.busy", 32'(busy8), 32'd0);
      chk("abort.done", 32'(done8), 32'd0);
      chk("abort.res",  32'(res8),  32'd0);
      #2 rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done8) ndone++;
      end
      chk("abort.no_done", 32'(ndone), 32'd0);
      chk("abort.res_after", 32'(res8), 32'd0);
      res_prev8 = '0;
      res_prev4 = '0;

      op8(8'd7, 8'd9, 16'd63, "post_rst");
      step();

      op4(4'd15, 4'd15, 8'd225, "w4max");
      step();
      op4(4'd0, 4'd0, 8'd0, "w4zero");
      step();
      for (int n = 0; n < 16; n++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         op4(ra, rb, 8'(ra) * 8'(rb), "w4rand");
         if (n[0]) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multiplication.md
MULTIPLICATION -- requirements
Module: multiplication

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are WIDTH >= 2.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a multiplication, sampled at the rising edge of clk.
REQ-005 The module SHALL have port A, input, WIDTH bits: unsigned multiplicand, sampled at start acceptance.
REQ-006 The module SHALL have port B, input, WIDTH bits: unsigned multiplier, sampled at start acceptance.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking that Res has been updated.
REQ-009 The module SHALL have port Res, output, 2*WIDTH bits: unsigned product of the last completed operation, registered.

Function
REQ-010 The module SHALL implement a two-state FSM, IDLE and RUN, using a sequential shift-and-add algorithm that examines one multiplier bit per clock.
REQ-011 In IDLE with start=1 at a rising edge, the module SHALL capture A and B, clear the partial product, load an iteration counter with WIDTH, set busy=1, and enter RUN.
REQ-012 In IDLE with start=0, the module SHALL hold all state and keep busy=0.
REQ-013 Each RUN edge SHALL add the zero-extended multiplicand to the upper part of the partial product if the current multiplier LSB is 1, shift the partial product/multiplier right by one with the carry retained, and decrement the counter.
REQ-014 Partial-product arithmetic SHALL be 2*WIDTH+1 bits wide internally, so no carry is lost; Res SHALL equal A*B exactly, modulo nothing.
REQ-015 On the RUN edge that completes iteration WIDTH, the module SHALL load Res with the product, set done=1, set busy=0, and return to IDLE.
REQ-016 Latency: when start is accepted at edge k, done and the new Res SHALL be visible in the cycle following edge k+WIDTH; busy SHALL be high from edge k to edge k+WIDTH.
REQ-017 done SHALL be high for exactly one cycle per completed operation and SHALL never assert without a preceding accepted start.
REQ-018 start SHALL be ignored while in RUN, and A and B changes during RUN SHALL NOT affect the result.
REQ-019 Res SHALL hold its value from one completion until the next completion; it SHALL NOT change at start acceptance.
REQ-020 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted, giving back-to-back operations with one done pulse each.
REQ-021 Operands of zero SHALL follow the same WIDTH-cycle timing, with no early termination.

Reset
REQ-022 While rst_n=0, the module SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, Res=0, and clear the counter and internal operand registers.
REQ-023 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow, and Res SHALL read 0.
REQ-024 After rst_n deasserts, the first rising edge SHALL behave as an IDLE edge and accept start if it is high.

Verification
REQ-025 Basic check, WIDTH=8: A=100, B=10, start pulse -> busy high for 8 edges, then done for 1 cycle with Res=1000.
REQ-026 Maximum operands, WIDTH=8: A=255, B=255 -> Res=65025 (16'hFE01); A=0, B=200 -> Res=0 with done at the same latency.
REQ-027 Start ignored while busy: start A=16, B=3, then reassert start mid-RUN with A=90, B=9 -> exactly one done, Res=48; busy timing unchanged.
REQ-028 Back-to-back operations: A=200, B=40 completes (Res=8000); start A=70, B=10 held in the done cycle -> second done WIDTH+1 cycles later with Res=700, and Res stays 8000 in between.
REQ-029 Reset mid-operation: pulse rst_n low asynchronously (between edges) during RUN of 255*5 -> busy, done, and Res go to 0 at once; no done after release.
REQ-030 Default WIDTH=4: A=15, B=15 -> Res=225 after 4 RUN edges; random A/B sweep checked against the reference product.
